// File: rtl/posit_acc_sched_pkg.sv
// Shared types and constants for the posit accumulation scheduler.
// The optional POSIT_ACC_NAR_STICKY_EN feature is selected in posit_acc_sched.sv.
package posit_acc_sched_pkg;

  localparam int NBITS      = 32;
  localparam int LAT        = 4;
  localparam int NSLOT      = 4;
  localparam int ACC_SLOT_W = $clog2(NSLOT);

  typedef struct packed {
    logic                  valid;
    logic [ACC_SLOT_W-1:0] slot;
  } acc_tag;

  typedef logic [1:0] acc_state;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [NBITS-1:0] POSIT_NAR = 32'h8000_0000;

endpackage

// File: rtl/posit_acc_sched_if.sv
// Operand stream, adder issue/return and result stream of the accumulation scheduler.
interface posit_acc_sched_if;
  import posit_acc_sched_pkg::*;

  logic [NBITS-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [NBITS-1:0] add_in1;
  logic [NBITS-1:0] add_in2;
  logic             add_start;
  logic [NBITS-1:0] add_result;
  logic             add_done;
  logic [NBITS-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             err;

  modport master (
    output in_data, in_valid, in_last, add_result, add_done, out_ready,
    input  in_ready, add_in1, add_in2, add_start, out_data, out_valid, err
  );

  modport slave (
    input  in_data, in_valid, in_last, add_result, add_done, out_ready,
    output in_ready, add_in1, add_in2, add_start, out_data, out_valid, err
  );

endinterface

// File: rtl/acc_tag_pipe.sv
// Shift register of {valid, slot} tags that mirrors the adder pipeline;
// the head lines up with the adder's done strobe.
module acc_tag_pipe
  import posit_acc_sched_pkg::*;
#(
  parameter int DEPTH = LAT
) (
  input  logic   clk,
  input  logic   clear,
  input  acc_tag tag_in,
  output acc_tag head
);

  acc_tag stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[DEPTH-1];

endmodule

// File: rtl/posit_acc_sched.sv
// Streaming posit accumulator around an external LAT-cycle adder, using NSLOT partial sums.
// Define POSIT_ACC_NAR_STICKY_EN to short-circuit a set to NaR once a NaR operand is seen.
module posit_acc_sched
  import posit_acc_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  posit_acc_sched_if.slave bus
);

  acc_state              state_q;
  logic [NBITS-1:0]      slot_data [NSLOT];
  logic [NSLOT-1:0]      slot_valid;
  logic [NSLOT-1:0]      slot_busy;
  logic [ACC_SLOT_W-1:0] ptr;
  logic                  err_q;
  logic                  nar_q;
  logic                  nar_in;
  acc_tag                head;
  acc_tag                issue_tag;

  logic                  in_rdy, accept, head_hit, fwd, store;
  logic                  acc_issue, drain_issue, wb_en, drain_done;
  logic [NBITS-1:0]      in1, in2, rem_data;
  logic [ACC_SLOT_W-1:0] pair_lo, pair_hi;
  logic                  pair_ok, lo_found;
  logic [ACC_SLOT_W:0]   n_valid;

`ifdef POSIT_ACC_NAR_STICKY_EN
  assign nar_in = (bus.in_data == POSIT_NAR);
`else
  assign nar_in = 1'b0;
`endif

  // Pick the two lowest idle partial sums for reduction and find the survivor.
  always_comb begin
    pair_ok  = 1'b0;
    lo_found = 1'b0;
    pair_lo  = '0;
    pair_hi  = '0;
    n_valid  = '0;
    rem_data = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_valid[i]) begin
        n_valid  = n_valid + (ACC_SLOT_W+1)'(1);
        rem_data = slot_data[i];
      end
      if (slot_valid[i] && !slot_busy[i]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          pair_lo  = ACC_SLOT_W'(i);
        end else if (!pair_ok) begin
          pair_ok = 1'b1;
          pair_hi = ACC_SLOT_W'(i);
        end
      end
    end
  end

  // A busy slot can still take a beat when its result returns this very cycle.
  always_comb begin
    head_hit = head.valid && (head.slot == ptr);
    case (state_q)
      IDLE:    in_rdy = 1'b1;
      ACCUM:   in_rdy = nar_q || !slot_busy[ptr] || head_hit;
      default: in_rdy = 1'b0;
    endcase
    if (reset) in_rdy = 1'b0;
    accept      = bus.in_valid && in_rdy;
    acc_issue   = 1'b0;
    drain_issue = 1'b0;
    fwd         = 1'b0;
    store       = 1'b0;
    in1         = '0;
    in2         = '0;
    issue_tag   = '0;
    if (accept && !nar_q && !nar_in) begin
      if (slot_busy[ptr]) begin
        acc_issue = 1'b1;
        fwd       = 1'b1;
        in2       = bus.add_result;
      end else if (slot_valid[ptr]) begin
        acc_issue = 1'b1;
        in2       = slot_data[ptr];
      end else begin
        store = 1'b1;
      end
      if (acc_issue) begin
        in1             = bus.in_data;
        issue_tag.valid = 1'b1;
        issue_tag.slot  = ptr;
      end
    end else if (state_q == DRAIN && pair_ok && !nar_q && !reset) begin
      drain_issue     = 1'b1;
      in1             = slot_data[pair_lo];
      in2             = slot_data[pair_hi];
      issue_tag.valid = 1'b1;
      issue_tag.slot  = pair_lo;
    end
    wb_en      = head.valid && !fwd;
    drain_done = nar_q ? (slot_busy == '0)
                       : ((n_valid == (ACC_SLOT_W+1)'(1)) && (slot_busy == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      slot_valid <= '0;
      slot_busy  <= '0;
      ptr        <= '0;
      err_q      <= 1'b0;
      nar_q      <= 1'b0;
    end else begin
      if (head.valid != bus.add_done) err_q <= 1'b1;
      if (wb_en) begin
        slot_data[head.slot]  <= bus.add_result;
        slot_valid[head.slot] <= 1'b1;
        slot_busy[head.slot]  <= 1'b0;
      end
      if (store) begin
        slot_data[ptr]  <= bus.in_data;
        slot_valid[ptr] <= 1'b1;
      end
      if (acc_issue) begin
        slot_valid[ptr] <= 1'b0;
        slot_busy[ptr]  <= 1'b1;
      end
      if (drain_issue) begin
        slot_valid[pair_lo] <= 1'b0;
        slot_busy[pair_lo]  <= 1'b1;
        slot_valid[pair_hi] <= 1'b0;
      end
      if (accept) begin
        ptr <= ptr + ACC_SLOT_W'(1);
        if (nar_in) nar_q <= 1'b1;
      end
      case (state_q)
        IDLE, ACCUM: if (accept) state_q <= bus.in_last ? DRAIN : ACCUM;
        DRAIN:       if (drain_done) state_q <= OUT;
        default: begin
          if (bus.out_ready) begin
            state_q    <= IDLE;
            slot_valid <= '0;
            slot_busy  <= '0;
            ptr        <= '0;
            nar_q      <= 1'b0;
          end
        end
      endcase
    end
  end

  acc_tag_pipe #(.DEPTH(LAT)) u_tag_pipe (
    .clk    (clk),
    .clear  (reset),
    .tag_in (issue_tag),
    .head   (head)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.add_start = acc_issue | drain_issue;
  assign bus.add_in1   = in1;
  assign bus.add_in2   = in2;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = (state_q == OUT) ? (nar_q ? POSIT_NAR : rem_data) : '0;
  assign bus.err       = err_q;

endmodule
